// File: rtl/gate_selftest.sv
// gate_selftest: drives four input vectors into a 2-input gate, samples it.
// Ports: clk, rst_n, start, dut_out in; dut_in1/2, busy, done, pass, err_count, fail_vec out.
module gate_selftest #(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] EXPECT_TT   = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] hold, hold_n;
  logic       in1_n, in2_n;
  logic       busy_n, done_n, pass_n;
  logic [2:0] err_n;
  logic [3:0] fail_n;
  logic       miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      dut_in1   <= 1'b0;
      dut_in2   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      hold      <= hold_n;
      dut_in1   <= in1_n;
      dut_in2   <= in2_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold;
    in1_n   = dut_in1;
    in2_n   = dut_in2;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_count;
    fail_n  = fail_vec;
    miss    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          hold_n  = '0;
          in1_n   = 1'b0;
          in2_n   = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          fail_n  = '0;
        end
      end
      RUN: begin
        if (hold == HOLD_LAST) begin
          // last hold cycle of this vector: sample and move on
          miss   = dut_out != EXPECT_TT[idx];
          hold_n = '0;
          if (miss) begin
            fail_n[idx] = 1'b1;
            err_n       = err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == 3'd0);
            in1_n   = 1'b0;
            in2_n   = 1'b0;
          end else begin
            idx_n = idx + 2'd1;
            in1_n = idx_n[0];
            in2_n = idx_n[1];
          end
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_selftest.sv
// tb_gate_selftest: randomized self-check of gate_selftest.
// Unit 0 uses HOLD_CYCLES=10, unit 1 uses HOLD_CYCLES=1; gates modelled by truth tables.
module tb_gate_selftest;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_s;
  logic [1:0] out_s;
  logic [1:0] in1_s, in2_s, busy_s, done_s, pass_s;
  logic [2:0] err_s  [2];
  logic [3:0] fail_s [2];
  logic [3:0] gate_tt [2];

  int nchk;
  int npass;

  localparam logic [3:0] AND_TT = 4'b1000;
  localparam logic [3:0] OR_TT  = 4'b1110;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_s[0] = gate_tt[0][{in2_s[0], in1_s[0]}];
  assign out_s[1] = gate_tt[1][{in2_s[1], in1_s[1]}];

  gate_selftest #(.HOLD_CYCLES(10), .EXPECT_TT(AND_TT)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dut_out(out_s[0]),
    .dut_in1(in1_s[0]), .dut_in2(in2_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .fail_vec(fail_s[0])
  );

  gate_selftest #(.HOLD_CYCLES(1), .EXPECT_TT(AND_TT)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dut_out(out_s[1]),
    .dut_in1(in1_s[1]), .dut_in2(in2_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .fail_vec(fail_s[1])
  );

  function automatic logic [11:0] outs(input int u);
    return {in1_s[u], in2_s[u], busy_s[u], done_s[u], pass_s[u],
            err_s[u], fail_s[u]};
  endfunction

  task automatic run_pass(input int u, input logic [3:0] tt,
                          input bit poke);
    int h;
    logic [3:0] efail;
    logic [2:0] eerr;
    logic [1:0] v;
    h = (u == 0) ? 10 : 1;
    gate_tt[u] = tt;
    efail = tt ^ AND_TT;
    eerr = 3'($countones(efail));
    @(posedge clk); #1 start_s[u] = 1'b1;
    @(posedge clk); #1 start_s[u] = 1'b0;
    for (int t = 0; t < 4 * h; t++) begin
      v = 2'(t / h);
      nchk++;
      if ({in2_s[u], in1_s[u]} !== v || busy_s[u] !== 1'b1 ||
          done_s[u] !== 1'b0)
        $display("FAIL run u%0d t%0d: vec=%b busy=%b done=%b want vec=%b busy=1 done=0",
                 u, t, {in2_s[u], in1_s[u]}, busy_s[u], done_s[u], v);
      else npass++;
      if (poke && t == 4) start_s[u] = 1'b1;
      if (poke && t == 5) start_s[u] = 1'b0;
      @(posedge clk); #1;
    end
    nchk++;
    if (done_s[u] !== 1'b1 || busy_s[u] !== 1'b0)
      $display("FAIL done u%0d tt=%b: done=%b busy=%b want 1/0",
               u, tt, done_s[u], busy_s[u]);
    else npass++;
    nchk++;
    if (fail_s[u] !== efail)
      $display("FAIL fail_vec u%0d tt=%b: got %b want %b",
               u, tt, fail_s[u], efail);
    else npass++;
    nchk++;
    if (err_s[u] !== eerr || pass_s[u] !== (eerr == 3'd0))
      $display("FAIL err/pass u%0d tt=%b: got %0d/%b want %0d/%b",
               u, tt, err_s[u], pass_s[u], eerr, eerr == 3'd0);
    else npass++;
    nchk++;
    if ({in2_s[u], in1_s[u]} !== 2'b00)
      $display("FAIL idle_in u%0d: got %b want 00",
               u, {in2_s[u], in1_s[u]});
    else npass++;
    @(posedge clk); #1;
    nchk++;
    if (done_s[u] !== 1'b1 || fail_s[u] !== efail || err_s[u] !== eerr)
      $display("FAIL hold u%0d: done=%b fail=%b err=%0d want 1/%b/%0d",
               u, done_s[u], fail_s[u], err_s[u], efail, eerr);
    else npass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_s = 2'b00;
    gate_tt[0] = AND_TT;
    gate_tt[1] = AND_TT;
    @(posedge clk); @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      nchk++;
      if (outs(u) !== 12'h000)
        $display("FAIL reset u%0d: got %h want 000", u, outs(u));
      else npass++;
    end
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    nchk++;
    if (outs(0) !== 12'h000 || outs(1) !== 12'h000)
      $display("FAIL idle_after_reset: got %h %h want 000 000",
               outs(0), outs(1));
    else npass++;
  endtask

  task automatic test_and;
    run_pass(0, AND_TT, 1'b0);
  endtask

  task automatic test_or;
    run_pass(0, OR_TT, 1'b0);
  endtask

  task automatic test_stuck;
    run_pass(0, 4'b1111, 1'b0);
    run_pass(0, 4'b0000, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_pass(0, AND_TT, 1'b1);
  endtask

  task automatic test_reset_mid;
    gate_tt[0] = 4'b1111;
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    nchk++;
    if (fail_s[0] !== 4'b0001 || busy_s[0] !== 1'b1)
      $display("FAIL pre_reset: fail=%b busy=%b want 0001/1",
               fail_s[0], busy_s[0]);
    else npass++;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (outs(0) !== 12'h000)
      $display("FAIL async_reset: got %h want 000", outs(0));
    else npass++;
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (outs(0) !== 12'h000)
      $display("FAIL post_reset_idle: got %h want 000", outs(0));
    else npass++;
  endtask

  task automatic test_hold1_back_to_back;
    run_pass(1, AND_TT, 1'b0);
    run_pass(1, AND_TT, 1'b0);
  endtask

  task automatic test_random;
    logic [3:0] tt;
    for (int k = 0; k < 6; k++) begin
      tt = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_pass(1, tt, 1'b0);
    end
    tt = 4'($urandom_range(0, 15));
    run_pass(0, tt, 1'b0);
  endtask

  initial begin
    nchk = 0;
    npass = 0;
    test_reset();
    test_and();
    test_or();
    test_stuck();
    test_start_ignored();
    test_reset_mid();
    test_hold1_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, sets the clocks each test vector is held; the legal range is 1..255.
REQ-002 Parameter EXPECT_TT, default 4'b1000, is the expected truth table; bit i is the expected dut_out for vector i (default is 2-input AND).
REQ-003 Port list (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run a test pass.
- dut_out  input  1  output of the gate under test.
- dut_in1  output  1  stimulus to the gate's in1.
- dut_in2  output  1  stimulus to the gate's in2.
- busy  output  1  a test pass is in progress.
- done  output  1  a test pass is complete; results are valid.
- pass  output  1  done with zero mismatches.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_vec  output  4  bit i set means vector i mismatched.
REQ-004 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-005 The FSM states SHALL be IDLE, RUN and DONE.
REQ-006 In IDLE or DONE, start=1 at an edge (E0) SHALL clear fail_vec, err_count, pass and done, set busy=1, load idx=0 and hold count=0, and enter RUN.
REQ-007 start SHALL be ignored while in RUN.
REQ-008 Vector order idx=0,1,2,3 SHALL drive {dut_in2,dut_in1} = 00, 01, 10, 11, i.e. dut_in1=idx[0] and dut_in2=idx[1].
REQ-009 dut_in1 and dut_in2 SHALL be registered outputs: the vector is valid from E0 and held for exactly HOLD_CYCLES clocks before the next vector appears.
REQ-010 Sampling: on the edge that ends the final hold cycle of vector i, dut_out SHALL be compared with EXPECT_TT[i]; on mismatch, fail_vec[i] SHALL be set and err_count incremented.
REQ-011 The hold counter SHALL count 0..HOLD_CYCLES-1 and wrap to 0 while idx advances; with HOLD_CYCLES=1 the vector changes every clock.
REQ-012 At edge E0+4*HOLD_CYCLES, after vector 3 is sampled, the block SHALL enter DONE with busy=0, done=1 and pass=(err_count==0).
- err_count and pass SHALL include the vector-3 result on that same edge.
REQ-013 In IDLE and DONE, dut_in1 and dut_in2 SHALL be 0.
REQ-014 In DONE, results SHALL hold until a new start or reset.
REQ-015 Restart from DONE SHALL behave exactly as a start from IDLE (REQ-006).
REQ-016 err_count SHALL always equal the popcount of fail_vec and SHALL never exceed 4.

Reset
REQ-017 rst_n=0 SHALL immediately, asynchronously of clk, force:
- state to IDLE;
- idx and hold count to 0;
- dut_in1, dut_in2, busy, done and pass to 0;
- err_count to 0 and fail_vec to 0.
REQ-018 Reset asserted mid-RUN SHALL abort the pass with no partial results retained.
REQ-019 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Behavioural AND model, HOLD=10, start pulse -> {dut_in2,dut_in1} = 00,01,10,11 for 10 clocks each; done=1 at E0+40; pass=1, err_count=0, fail_vec=0000.
- OR model, HOLD=10 -> fail_vec=0110, err_count=2, pass=0 at E0+40.
- dut_out stuck at 1 -> fail_vec=0111, err_count=3, pass=0; stuck at 0 -> fail_vec=1000, err_count=1, pass=0.
- start pulsed again at E0+5 during RUN -> no effect; the sequence and done timing are unchanged.
- rst_n low at E0+15 -> all outputs 0 without waiting for a clock edge; after release, state is IDLE and done stays 0 until a new start.
- HOLD=1, AND model -> the vector changes every clock; done at E0+4 with pass=1; a second start from DONE clears done the next cycle and repeats identically.
